lsu_reorder_buffer: RTL and testbench

Tagged in-order request buffer between the load/store unit and `l1_data_cache`. It accepts core memory requests, assigns each a tag equal to its buffer slot, and issues them to the L1D in program order. The L1D may complete requests out of order (MSHR hits under misses). This block reorders the completions so the core sees responses strictly in request order.

---
 rtl/lsu_rob_pkg.sv | 19 +
 rtl/lsu_reorder_buffer.sv | 115 +++++++++++
 tb/tb_lsu_reorder_buffer.sv | 368 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_rob_pkg.sv
// Shared types for the LSU reorder buffer: per-entry lifecycle state and
// the packed entry record held in each slot.
package lsu_rob_pkg;

  typedef enum logic [1:0] {
    ROB_FREE    = 2'd0,
    ROB_PENDING = 2'd1,
    ROB_ISSUED  = 2'd2,
    ROB_DONE    = 2'd3
  } rob_state_e;

  typedef struct packed {
    rob_state_e  state;
    logic        we;
    logic [63:0] addr;
    logic [63:0] value;
  } rob_entry_t;

endpackage

// File: rtl/lsu_reorder_buffer.sv
// In-order tagged request buffer in front of the L1D. Requests issue in
// program order, completions may return out of order, retirement is in order.
module lsu_reorder_buffer
  import lsu_rob_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int TAG_BITS = 10
) (
  input  logic                clk_in,
  input  logic                rst_N_in,
  input  logic                core_valid_in,
  output logic                core_ready_out,
  input  logic [63:0]         core_addr_in,
  input  logic [63:0]         core_value_in,
  input  logic                core_we_in,
  output logic                core_valid_out,
  input  logic                core_ready_in,
  output logic [63:0]         core_addr_out,
  output logic [63:0]         core_value_out,
  output logic                core_we_out,
  output logic                l1d_valid_out,
  input  logic                l1d_ready_in,
  output logic [63:0]         l1d_addr_out,
  output logic [63:0]         l1d_value_out,
  output logic                l1d_we_out,
  output logic [TAG_BITS-1:0] l1d_tag_out,
  input  logic                l1d_valid_in,
  output logic                l1d_ready_out,
  input  logic [63:0]         l1d_value_in,
  input  logic                l1d_write_complete_in,
  input  logic [TAG_BITS-1:0] l1d_tag_in,
  output logic                err_out
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = IW + 1;

  rob_entry_t    r_ent [DEPTH];
  logic [IW-1:0] r_alloc, r_issue, r_retire;
  logic [CW-1:0] r_count;
  logic          r_live;
  logic          r_err;

  rob_entry_t    w_iss_e, w_ret_e;
  logic [IW-1:0] w_cpl_idx;
  logic          w_alloc, w_issue, w_cpl, w_cpl_ok, w_retire, w_tag_hi_bad;

  assign w_iss_e = r_ent[r_issue];
  assign w_ret_e = r_ent[r_retire];

  // r_live holds both readies low during reset and for the first cycle after
  assign core_ready_out = r_live && (r_count != CW'(DEPTH));
  assign l1d_ready_out  = r_live;
  assign err_out        = r_err;

  assign l1d_valid_out = (w_iss_e.state == ROB_PENDING);
  assign l1d_addr_out  = l1d_valid_out ? w_iss_e.addr  : 64'd0;
  assign l1d_value_out = l1d_valid_out ? w_iss_e.value : 64'd0;
  assign l1d_we_out    = l1d_valid_out && w_iss_e.we;
  assign l1d_tag_out   = l1d_valid_out ? TAG_BITS'(r_issue) : '0;

  assign core_valid_out = (w_ret_e.state == ROB_DONE);
  assign core_addr_out  = core_valid_out ? w_ret_e.addr  : 64'd0;
  assign core_value_out = core_valid_out ? w_ret_e.value : 64'd0;
  assign core_we_out    = core_valid_out && w_ret_e.we;

  assign w_alloc      = core_valid_in && core_ready_out;
  assign w_issue      = l1d_valid_out && l1d_ready_in;
  assign w_retire     = core_valid_out && core_ready_in;
  assign w_cpl_idx    = l1d_tag_in[IW-1:0];
  assign w_tag_hi_bad = ((l1d_tag_in >> IW) != '0);
  assign w_cpl        = l1d_valid_in && r_live;
  assign w_cpl_ok     = w_cpl && !w_tag_hi_bad && (r_ent[w_cpl_idx].state == ROB_ISSUED);

  // The four events always hit different slots since each needs a distinct state
  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      for (int i = 0; i < DEPTH; i++) r_ent[i] <= '0;
      r_alloc  <= '0;
      r_issue  <= '0;
      r_retire <= '0;
      r_count  <= '0;
      r_live   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_live <= 1'b1;
      if (w_alloc) begin
        r_ent[r_alloc] <= '{state: ROB_PENDING, we: core_we_in, addr: core_addr_in,
                            value: core_we_in ? core_value_in : 64'd0};
        r_alloc <= r_alloc + 1'b1;
      end
      if (w_issue) begin
        r_ent[r_issue].state <= ROB_ISSUED;
        r_issue <= r_issue + 1'b1;
      end
      if (w_cpl_ok) begin
        r_ent[w_cpl_idx].state <= ROB_DONE;
        r_ent[w_cpl_idx].value <= (r_ent[w_cpl_idx].we || l1d_write_complete_in) ?
                                  64'd0 : l1d_value_in;
      end else if (w_cpl) begin
        r_err <= 1'b1;
      end
      if (w_retire) begin
        r_ent[r_retire].state <= ROB_FREE;
        r_retire <= r_retire + 1'b1;
      end
      case ({w_alloc, w_retire})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_reorder_buffer.sv
// Scoreboard bench for lsu_reorder_buffer: requests are queued on accept,
// checked against L1D issue order and again against in-order retirement.
module tb_lsu_reorder_buffer;

  localparam int DEPTH    = 4;
  localparam int TAG_BITS = 10;

  typedef struct {
    logic [63:0] addr;
    logic        we;
    logic [63:0] val;
    int          tag;
  } exp_t;

  logic                clk_in = 1'b0;
  logic                rst_N_in = 1'b0;
  logic                core_valid_in = 1'b0, core_we_in = 1'b0, core_ready_in = 1'b0;
  logic [63:0]         core_addr_in = '0, core_value_in = '0;
  logic                core_ready_out, core_valid_out, core_we_out;
  logic [63:0]         core_addr_out, core_value_out;
  logic                l1d_valid_out, l1d_we_out, l1d_ready_out, err_out;
  logic                l1d_ready_in = 1'b0, l1d_valid_in = 1'b0, l1d_write_complete_in = 1'b0;
  logic [63:0]         l1d_addr_out, l1d_value_out, l1d_value_in = '0;
  logic [TAG_BITS-1:0] l1d_tag_out, l1d_tag_in = '0;

  int          total = 0, bad = 0;
  int          a_cnt = 0;
  logic [63:0] cur_ldata = '0;
  logic [63:0] plan [DEPTH];
  exp_t        exp_q [$];
  exp_t        iss_q [$];
  logic        did_iss = 1'b0;
  int          iss_tag = 0;

  lsu_reorder_buffer #(.DEPTH(DEPTH), .TAG_BITS(TAG_BITS)) dut (
    .clk_in(clk_in), .rst_N_in(rst_N_in),
    .core_valid_in(core_valid_in), .core_ready_out(core_ready_out),
    .core_addr_in(core_addr_in), .core_value_in(core_value_in), .core_we_in(core_we_in),
    .core_valid_out(core_valid_out), .core_ready_in(core_ready_in),
    .core_addr_out(core_addr_out), .core_value_out(core_value_out), .core_we_out(core_we_out),
    .l1d_valid_out(l1d_valid_out), .l1d_ready_in(l1d_ready_in),
    .l1d_addr_out(l1d_addr_out), .l1d_value_out(l1d_value_out), .l1d_we_out(l1d_we_out),
    .l1d_tag_out(l1d_tag_out), .l1d_valid_in(l1d_valid_in), .l1d_ready_out(l1d_ready_out),
    .l1d_value_in(l1d_value_in), .l1d_write_complete_in(l1d_write_complete_in),
    .l1d_tag_in(l1d_tag_in), .err_out(err_out)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, required finish before 200000");
    $fatal(1);
  end

  // Records every handshake about to happen at the coming edge, then advances.
  task automatic tick();
    exp_t e;
    if (core_valid_in && core_ready_out) begin
      e.addr = core_addr_in; e.we = core_we_in; e.tag = a_cnt % DEPTH;
      e.val  = core_we_in ? core_value_in : 64'd0;
      iss_q.push_back(e);
      e.val = core_we_in ? 64'd0 : cur_ldata;
      plan[e.tag] = cur_ldata;
      exp_q.push_back(e);
      a_cnt++;
    end
    did_iss = 1'b0;
    if (l1d_valid_out && l1d_ready_in) begin
      did_iss = 1'b1; iss_tag = int'(l1d_tag_out);
      total++;
      if (iss_q.size() == 0) begin
        bad++; $display("FAIL issue_spurious: got tag %0d, required no issue", l1d_tag_out);
      end else begin
        e = iss_q.pop_front();
        if (l1d_addr_out !== e.addr || l1d_we_out !== e.we || l1d_tag_out !== TAG_BITS'(e.tag) ||
            (e.we && l1d_value_out !== e.val)) begin
          bad++;
          $display("FAIL issue_order: got addr=%h we=%b tag=%0d val=%h, required addr=%h we=%b tag=%0d val=%h",
                   l1d_addr_out, l1d_we_out, l1d_tag_out, l1d_value_out, e.addr, e.we, e.tag, e.val);
        end
      end
    end
    if (core_valid_out && core_ready_in) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++; $display("FAIL retire_spurious: got addr=%h, required no response", core_addr_out);
      end else begin
        e = exp_q.pop_front();
        if (core_addr_out !== e.addr || core_we_out !== e.we || core_value_out !== e.val) begin
          bad++;
          $display("FAIL retire_order: got addr=%h we=%b val=%h, required addr=%h we=%b val=%h",
                   core_addr_out, core_we_out, core_value_out, e.addr, e.we, e.val);
        end
      end
    end
    @(posedge clk_in); #1;
  endtask

  task automatic send(input logic [63:0] a, input logic w, input logic [63:0] v, input logic [63:0] ld);
    int n = 0;
    core_valid_in = 1'b1; core_addr_in = a; core_we_in = w; core_value_in = v; cur_ldata = ld;
    while (!core_ready_out && n < 20) begin tick(); n++; end
    total++;
    if (!core_ready_out) begin bad++; $display("FAIL send_timeout: got ready=0, required ready=1"); end
    tick();
    core_valid_in = 1'b0; core_addr_in = '0; core_we_in = 1'b0; core_value_in = '0;
  endtask

  task automatic respond(input logic [TAG_BITS-1:0] t, input logic [63:0] v, input logic wc);
    l1d_valid_in = 1'b1; l1d_tag_in = t; l1d_value_in = v; l1d_write_complete_in = wc;
    tick();
    l1d_valid_in = 1'b0; l1d_tag_in = '0; l1d_value_in = '0; l1d_write_complete_in = 1'b0;
  endtask

  task automatic apply_reset();
    core_valid_in = 1'b0; l1d_valid_in = 1'b0; core_ready_in = 1'b0; l1d_ready_in = 1'b0;
    rst_N_in = 1'b0;
    @(posedge clk_in); #1;
    rst_N_in = 1'b1;
    @(posedge clk_in); #1;
    @(posedge clk_in); #1;
    exp_q.delete(); iss_q.delete(); a_cnt = 0;
  endtask

  task automatic test_reset();
    #2;
    total++;
    if (core_valid_out !== 1'b0 || l1d_valid_out !== 1'b0 || l1d_ready_out !== 1'b0 ||
        core_ready_out !== 1'b0 || err_out !== 1'b0 || core_addr_out !== 64'd0 ||
        l1d_addr_out !== 64'd0 || l1d_tag_out !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got cv=%b lv=%b lr=%b cr=%b err=%b, required all 0",
               core_valid_out, l1d_valid_out, l1d_ready_out, core_ready_out, err_out);
    end
    @(posedge clk_in); #1;
    rst_N_in = 1'b1;
    @(posedge clk_in); #1;
    @(posedge clk_in); #1;
    total++;
    if (core_ready_out !== 1'b1 || l1d_ready_out !== 1'b1) begin
      bad++; $display("FAIL reset_release: got cr=%b lr=%b, required 1 1", core_ready_out, l1d_ready_out);
    end
  endtask

  task automatic test_single_load();
    apply_reset();
    l1d_ready_in = 1'b1;
    send(64'h2000, 1'b0, 64'd0, 64'h12345678);
    total++;
    if (l1d_valid_out !== 1'b1 || l1d_tag_out !== 10'd0) begin
      bad++; $display("FAIL single_issue: got v=%b tag=%0d, required v=1 tag=0", l1d_valid_out, l1d_tag_out);
    end
    tick();
    total++;
    if (core_valid_out !== 1'b0) begin bad++; $display("FAIL single_early: got cv=%b, required 0", core_valid_out); end
    respond(10'd0, 64'h12345678, 1'b0);
    total++;
    if (core_valid_out !== 1'b1 || core_value_out !== 64'h12345678 || core_we_out !== 1'b0) begin
      bad++; $display("FAIL single_rsp: got cv=%b val=%h we=%b, required 1 12345678 0",
                      core_valid_out, core_value_out, core_we_out);
    end
    core_ready_in = 1'b1; tick(); core_ready_in = 1'b0;
    total++;
    if (exp_q.size() != 0 || core_valid_out !== 1'b0) begin
      bad++; $display("FAIL single_drain: got left=%0d cv=%b, required 0 0", exp_q.size(), core_valid_out);
    end
  endtask

  task automatic test_out_of_order();
    apply_reset();
    l1d_ready_in = 1'b1;
    send(64'h1000, 1'b0, 64'd0, 64'hCAFE);
    send(64'h60300, 1'b0, 64'd0, 64'hBEEF);
    tick();
    respond(10'd1, 64'hBEEF, 1'b0);
    total++;
    if (core_valid_out !== 1'b0) begin bad++; $display("FAIL ooo_hold: got cv=%b, required 0", core_valid_out); end
    respond(10'd0, 64'hCAFE, 1'b0);
    total++;
    if (core_valid_out !== 1'b1 || core_value_out !== 64'hCAFE || core_addr_out !== 64'h1000) begin
      bad++; $display("FAIL ooo_first: got cv=%b val=%h addr=%h, required 1 cafe 1000",
                      core_valid_out, core_value_out, core_addr_out);
    end
    core_ready_in = 1'b1;
    tick();
    total++;
    if (core_valid_out !== 1'b1 || core_value_out !== 64'hBEEF || core_addr_out !== 64'h60300) begin
      bad++; $display("FAIL ooo_second: got cv=%b val=%h addr=%h, required 1 beef 60300",
                      core_valid_out, core_value_out, core_addr_out);
    end
    tick(); core_ready_in = 1'b0;
    total++;
    if (core_valid_out !== 1'b0 || exp_q.size() != 0) begin
      bad++; $display("FAIL ooo_drain: got cv=%b left=%0d, required 0 0", core_valid_out, exp_q.size());
    end
  endtask

  task automatic test_full();
    apply_reset();
    l1d_ready_in = 1'b1;
    for (int i = 0; i < DEPTH; i++) send(64'h5000 + 64'(i * 8), 1'b0, 64'd0, 64'hA0 + 64'(i));
    total++;
    if (core_ready_out !== 1'b0) begin bad++; $display("FAIL full_ready: got %b, required 0", core_ready_out); end
    core_valid_in = 1'b1; core_addr_in = 64'h5100; core_we_in = 1'b0; cur_ldata = 64'hA5;
    tick(); tick();
    total++;
    if (exp_q.size() != DEPTH) begin bad++; $display("FAIL full_overflow: got %0d queued, required %0d", exp_q.size(), DEPTH); end
    respond(10'd0, plan[0], 1'b0);
    total++;
    if (core_valid_out !== 1'b1 || core_ready_out !== 1'b0) begin
      bad++; $display("FAIL full_done: got cv=%b cr=%b, required 1 0", core_valid_out, core_ready_out);
    end
    core_ready_in = 1'b1; tick(); core_ready_in = 1'b0;
    total++;
    if (core_ready_out !== 1'b1) begin bad++; $display("FAIL full_reopen: got %b, required 1", core_ready_out); end
    tick();
    core_valid_in = 1'b0;
    total++;
    if (l1d_valid_out !== 1'b1 || l1d_tag_out !== 10'd0 || l1d_addr_out !== 64'h5100) begin
      bad++; $display("FAIL full_wrap: got v=%b tag=%0d addr=%h, required 1 0 5100",
                      l1d_valid_out, l1d_tag_out, l1d_addr_out);
    end
    tick();
    core_ready_in = 1'b1;
    for (int t = 1; t <= DEPTH; t++) respond(10'(t % DEPTH), plan[t % DEPTH], 1'b0);
    tick(); tick();
    core_ready_in = 1'b0;
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL full_drain: got %0d left, required 0", exp_q.size()); end
  endtask

  task automatic test_backpressure();
    apply_reset();
    send(64'h3000, 1'b0, 64'd0, 64'h55);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (l1d_valid_out !== 1'b1 || l1d_addr_out !== 64'h3000 || l1d_tag_out !== 10'd0) begin
        bad++; $display("FAIL bp_req_stable: got v=%b addr=%h tag=%0d, required 1 3000 0",
                        l1d_valid_out, l1d_addr_out, l1d_tag_out);
      end
      tick();
    end
    l1d_ready_in = 1'b1; tick(); l1d_ready_in = 1'b0;
    total++;
    if (l1d_valid_out !== 1'b0 || iss_q.size() != 0) begin
      bad++; $display("FAIL bp_issue_once: got v=%b left=%0d, required 0 0", l1d_valid_out, iss_q.size());
    end
    respond(10'd0, 64'h55, 1'b0);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (core_valid_out !== 1'b1 || core_value_out !== 64'h55 || core_addr_out !== 64'h3000) begin
        bad++; $display("FAIL bp_rsp_stable: got v=%b val=%h addr=%h, required 1 55 3000",
                        core_valid_out, core_value_out, core_addr_out);
      end
      tick();
    end
    core_ready_in = 1'b1; tick(); core_ready_in = 1'b0;
    total++;
    if (core_valid_out !== 1'b0 || exp_q.size() != 0) begin
      bad++; $display("FAIL bp_drain: got cv=%b left=%0d, required 0 0", core_valid_out, exp_q.size());
    end
  endtask

  task automatic test_bogus_tag();
    apply_reset();
    respond(10'd2, 64'hDEAD, 1'b0);
    tick(); tick();
    total++;
    if (err_out !== 1'b1 || core_valid_out !== 1'b0) begin
      bad++; $display("FAIL bogus_free: got err=%b cv=%b, required 1 0", err_out, core_valid_out);
    end
    apply_reset();
    l1d_ready_in = 1'b1;
    send(64'h9000, 1'b0, 64'd0, 64'h99);
    tick();
    respond(10'h104, 64'h77, 1'b0);
    total++;
    if (err_out !== 1'b1 || core_valid_out !== 1'b0) begin
      bad++; $display("FAIL bogus_hibits: got err=%b cv=%b, required 1 0", err_out, core_valid_out);
    end
    respond(10'd0, 64'h99, 1'b0);
    core_ready_in = 1'b1; tick(); core_ready_in = 1'b0;
    total++;
    if (exp_q.size() != 0 || err_out !== 1'b1) begin
      bad++; $display("FAIL bogus_recover: got left=%0d err=%b, required 0 1", exp_q.size(), err_out);
    end
  endtask

  task automatic test_mixed_reset();
    apply_reset();
    l1d_ready_in = 1'b1;
    send(64'h4050, 1'b1, 64'hC0C0C0C0, 64'd0);
    send(64'h4050, 1'b0, 64'd0, 64'h77);
    tick();
    respond(10'd0, 64'hFFFF, 1'b1);
    respond(10'd1, 64'h77, 1'b0);
    total++;
    if (core_valid_out !== 1'b1 || core_we_out !== 1'b1 || core_value_out !== 64'd0) begin
      bad++; $display("FAIL mixed_store: got cv=%b we=%b val=%h, required 1 1 0",
                      core_valid_out, core_we_out, core_value_out);
    end
    core_ready_in = 1'b1; tick(); tick(); core_ready_in = 1'b0;
    send(64'h7000, 1'b0, 64'd0, 64'h1);
    send(64'h7008, 1'b0, 64'd0, 64'h2);
    tick();
    rst_N_in = 1'b0; #1;
    total++;
    if (core_valid_out !== 1'b0 || l1d_valid_out !== 1'b0 || l1d_ready_out !== 1'b0 ||
        core_ready_out !== 1'b0 || core_addr_out !== 64'd0 || l1d_addr_out !== 64'd0) begin
      bad++; $display("FAIL midreset_outputs: got cv=%b lv=%b lr=%b cr=%b, required all 0",
                      core_valid_out, l1d_valid_out, l1d_ready_out, core_ready_out);
    end
    @(posedge clk_in); #1;
    rst_N_in = 1'b1;
    exp_q.delete(); iss_q.delete(); a_cnt = 0;
    @(posedge clk_in); #1;
    @(posedge clk_in); #1;
    total++;
    if (core_ready_out !== 1'b1) begin bad++; $display("FAIL midreset_ready: got %b, required 1", core_ready_out); end
    respond(10'd0, 64'h1, 1'b0);
    total++;
    if (err_out !== 1'b1 || core_valid_out !== 1'b0) begin
      bad++; $display("FAIL midreset_stale: got err=%b cv=%b, required 1 0", err_out, core_valid_out);
    end
  endtask

  task automatic test_back_to_back();
    int sent = 0, cyc = 0;
    logic rsp_pend = 1'b0;
    int   rsp_tag = 0;
    apply_reset();
    l1d_ready_in = 1'b1; core_ready_in = 1'b1;
    while ((sent < 8 || exp_q.size() != 0) && cyc < 40) begin
      core_valid_in = (sent < 8);
      core_addr_in  = 64'h8000 + 64'(sent * 8);
      core_we_in    = 1'b0;
      cur_ldata     = 64'hF000 + 64'(sent);
      if (core_valid_in && core_ready_out) sent++;
      l1d_valid_in = rsp_pend;
      l1d_tag_in   = 10'(rsp_tag);
      l1d_value_in = plan[rsp_tag % DEPTH];
      tick();
      rsp_pend = did_iss; rsp_tag = iss_tag;
      cyc++;
    end
    core_valid_in = 1'b0; l1d_valid_in = 1'b0; core_ready_in = 1'b0;
    total++;
    if (sent != 8 || exp_q.size() != 0 || cyc > 12) begin
      bad++; $display("FAIL b2b_throughput: got sent=%0d left=%0d cycles=%0d, required 8 0 <=12",
                      sent, exp_q.size(), cyc);
    end
  endtask

  initial begin
    test_reset();
    test_single_load();
    test_out_of_order();
    test_full();
    test_backpressure();
    test_bogus_tag();
    test_mixed_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
